// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap_timer stopwatch/countdown core.
// Digits are stored BCD, most significant minute digit first.
package lap_timer_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
        bcd_t h1;
        bcd_t h0;
    } time_t;

    localparam int MOD_H0 = 10;
    localparam int MOD_H1 = 10;
    localparam int MOD_S0 = 10;
    localparam int MOD_S1 = 6;
    localparam int MOD_M0 = 10;
    localparam int MOD_M1 = 6;

    localparam time_t TIME_ZERO = 24'h00_00_00;
    localparam time_t TIME_MAX  = 24'h59_59_99;

    // Digit index 0 is h0, index 5 is m1.
    function automatic int digit_mod(input int idx);
        case (idx)
            0:       return MOD_H0;
            1:       return MOD_H1;
            2:       return MOD_S0;
            3:       return MOD_S1;
            4:       return MOD_M0;
            default: return MOD_M1;
        endcase
    endfunction

    function automatic bcd_t sat_digit(input bcd_t d, input int m);
        return (int'(d) > m - 1) ? bcd_t'(m - 1) : d;
    endfunction

    function automatic time_t sat_time(input logic [23:0] v);
        time_t t;
        time_t r;
        t    = v;
        r.m1 = sat_digit(t.m1, MOD_M1);
        r.m0 = sat_digit(t.m0, MOD_M0);
        r.s1 = sat_digit(t.s1, MOD_S1);
        r.s0 = sat_digit(t.s0, MOD_S0);
        r.h1 = sat_digit(t.h1, MOD_H1);
        r.h0 = sat_digit(t.h0, MOD_H0);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit of modulus MOD with load, up/down step and carry/borrow out.
// Updates one cycle after en/load; no backpressure, co is the combinational terminal flag.
module bcd_digit
    import lap_timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic down,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t q,
    output logic co
);

    localparam bcd_t TOP = bcd_t'(MOD - 1);

    assign co = down ? (q == 4'd0) : (q == TOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (down) q <= (q == 4'd0) ? TOP : q - 4'd1;
            else      q <= (q == TOP)  ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/lap_timer.sv
// MM:SS:hh BCD stopwatch/countdown with run/pause FSM and a LAP_DEPTH split-time FIFO.
// Commands act one cycle after the pulse; full FIFO drops new laps and sets sticky lap_ovf.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic                         start_stop,
    input  logic                         clear,
    input  logic                         lap,
    input  logic                         lap_rd,
    input  logic                         mode,
    input  logic [23:0]                  preset,
    output logic [23:0]                  time_bcd,
    output logic [23:0]                  lap_bcd,
    output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
    output logic                         lap_ovf,
    output logic                         running,
    output logic                         expired,
    output logic                         wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;

    state_t        state;
    logic [PW-1:0] presc;
    logic          mode_q;
    time_t         cur;
    logic [23:0]   load_vec;
    logic          load;
    bcd_t          q [6];
    logic [5:0]    en;
    logic [5:0]    co;

    logic tick, start_idle, expire_now, wrap_now;

    assign tick       = (state == ST_RUN) && (presc == PW'(DIV - 1)) && !clear;
    assign start_idle = start_stop && !clear && (state == ST_IDLE);
    // Only 00:00:01 (or an empty preset) can step to zero on a down tick.
    assign expire_now = tick && mode_q &&
                        ({cur.m1, cur.m0, cur.s1, cur.s0, cur.h1} == 20'h0) && (cur.h0 <= 4'd1);

    always_comb begin
        load     = 1'b0;
        load_vec = TIME_ZERO;
        if (clear) begin
            load     = 1'b1;
            load_vec = mode ? sat_time(preset) : TIME_ZERO;
        end else if (start_idle && mode && (cur == TIME_ZERO)) begin
            load     = 1'b1;
            load_vec = sat_time(preset);
        end else if (expire_now) begin
            load     = 1'b1;
            load_vec = TIME_ZERO;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign en[0] = tick && !load;
        end else begin : g_cascade
            assign en[i] = tick && !load && (&co[i-1:0]);
        end
        bcd_digit #(.MOD(digit_mod(i))) u_digit (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .down     (mode_q),
            .load     (load),
            .load_val (load_vec[4*i +: 4]),
            .q        (q[i]),
            .co       (co[i])
        );
    end

    assign cur      = {q[5], q[4], q[3], q[2], q[1], q[0]};
    assign wrap_now = en[5] && co[5] && !mode_q;
    assign time_bcd = cur;
    assign running  = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            mode_q  <= 1'b0;
            wrap    <= 1'b0;
            expired <= 1'b0;
        end else begin
            wrap    <= wrap_now;
            expired <= expire_now;
            if (clear || start_idle)  presc <= '0;
            else if (state == ST_RUN) presc <= tick ? '0 : presc + PW'(1);
            if (start_idle) mode_q <= mode;
            if (clear) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  if (start_stop) state <= ST_RUN;
                    ST_RUN:   if (expire_now) state <= ST_DONE;
                              else if (start_stop) state <= ST_PAUSE;
                    ST_PAUSE: if (start_stop) state <= ST_RUN;
                    default:  state <= ST_DONE;
                endcase
            end
        end
    end

    // Lap FIFO: simultaneous push and pop pass through even when full or empty.
    time_t         mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          lap_ok, rd_req, full, empty, do_push, do_pop;
    logic [23:0]   head_nxt;

    assign lap_ok  = lap && !clear && ((state == ST_RUN) || (state == ST_PAUSE));
    assign rd_req  = lap_rd && !clear;
    assign full    = (lap_cnt == CW'(LAP_DEPTH));
    assign empty   = (lap_cnt == '0);
    assign do_push = lap_ok && (!full || rd_req);
    assign do_pop  = rd_req && (!empty || lap_ok);
    assign rd_nxt  = rd_ptr + AW'(do_pop);
    assign cnt_nxt = lap_cnt + CW'(do_push) - CW'(do_pop);

    always_comb begin
        head_nxt = 24'h0;
        if (cnt_nxt != '0) begin
            if (do_push && (wr_ptr == rd_nxt)) head_nxt = cur;
            else                                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= cur;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            lap_bcd <= 24'h0;
            lap_ovf <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            lap_bcd <= 24'h0;
            lap_ovf <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_nxt;
            lap_cnt <= cnt_nxt;
            lap_bcd <= head_nxt;
            if (lap_ok && full && !rd_req) lap_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer at 10 clocks per tick with a 4-entry lap FIFO.
module tb_lap_timer;

    logic        rst, clk;
    logic        start_stop, clear, lap, lap_rd, mode;
    logic [23:0] preset;
    logic [23:0] time_bcd, lap_bcd;
    logic [2:0]  lap_cnt;
    logic        lap_ovf, running, expired, wrap;

    int tests    = 0;
    int failures = 0;

    lap_timer #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4)) dut (
        .rst        (rst),
        .clk        (clk),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .lap_rd     (lap_rd),
        .mode       (mode),
        .preset     (preset),
        .time_bcd   (time_bcd),
        .lap_bcd    (lap_bcd),
        .lap_cnt    (lap_cnt),
        .lap_ovf    (lap_ovf),
        .running    (running),
        .expired    (expired),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; asserts the pulses for exactly one clock edge.
    task automatic cmd(input logic ss, input logic cl, input logic lp, input logic rd);
        start_stop = ss; clear = cl; lap = lp; lap_rd = rd;
        @(posedge clk); #1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        ss, cl, lp, rd, md;
        logic [23:0] pre;
        int          w;
        logic [23:0] t;
        logic        run;
        logic [2:0]  cnt;
        logic        ovf;
        logic [23:0] lb;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int n_exp;

        //            ss  cl  lp  rd  md  pre        w   time       run cnt ovf lap_bcd
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,24'h0,      0, 24'h000000,1'b0,3'd0,1'b0,24'h000000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,24'h0,     14, 24'h000001,1'b1,3'd0,1'b0,24'h000000};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      9, 24'h000002,1'b1,3'd1,1'b0,24'h000001};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      9, 24'h000003,1'b1,3'd2,1'b0,24'h000001};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      9, 24'h000004,1'b1,3'd3,1'b0,24'h000001};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      9, 24'h000005,1'b1,3'd4,1'b0,24'h000001};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      9, 24'h000006,1'b1,3'd4,1'b1,24'h000001};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,24'h0,      0, 24'h000006,1'b0,3'd4,1'b1,24'h000001};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd4,1'b1,24'h000002};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd3,1'b1,24'h000003};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd2,1'b1,24'h000004};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd1,1'b1,24'h000006};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd0,1'b1,24'h000000};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd0,1'b1,24'h000000};
        tbl[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0,24'h0,      0, 24'h000006,1'b0,3'd0,1'b1,24'h000000};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,24'h0,      4, 24'h000006,1'b1,3'd0,1'b1,24'h000000};
        tbl[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      0, 24'h000007,1'b1,3'd1,1'b1,24'h000006};
        tbl[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,24'h0,      0, 24'h000000,1'b0,3'd0,1'b0,24'h000000};
        tbl[18] = '{1'b0,1'b0,1'b1,1'b0,1'b0,24'h0,      0, 24'h000000,1'b0,3'd0,1'b0,24'h000000};
        tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b1,24'h007A0F, 0, 24'h005909,1'b0,3'd0,1'b0,24'h000000};

        rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
        mode = 1'b0; preset = 24'h0;
        cycles(3);
        chk("reset time_bcd", 32'(time_bcd), 32'h0);
        chk("reset lap_bcd",  32'(lap_bcd),  32'h0);
        chk("reset lap_cnt",  32'(lap_cnt),  32'h0);
        chk("reset lap_ovf",  32'(lap_ovf),  32'h0);
        chk("reset running",  32'(running),  32'h0);
        chk("reset expired",  32'(expired),  32'h0);
        chk("reset wrap",     32'(wrap),     32'h0);
        rst = 1'b1;
        cycles(2);

        for (int i = 0; i < 20; i++) begin
            mode   = tbl[i].md;
            preset = tbl[i].pre;
            cmd(tbl[i].ss, tbl[i].cl, tbl[i].lp, tbl[i].rd);
            cycles(tbl[i].w);
            chk($sformatf("vec%0d time_bcd", i), 32'(time_bcd), 32'(tbl[i].t));
            chk($sformatf("vec%0d running", i),  32'(running),  32'(tbl[i].run));
            chk($sformatf("vec%0d lap_cnt", i),  32'(lap_cnt),  32'(tbl[i].cnt));
            chk($sformatf("vec%0d lap_ovf", i),  32'(lap_ovf),  32'(tbl[i].ovf));
            chk($sformatf("vec%0d lap_bcd", i),  32'(lap_bcd),  32'(tbl[i].lb));
        end

        // 1000 ticks of up counting from zero.
        mode = 1'b0; preset = 24'h0;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(9999);
        chk("up 999 ticks", 32'(time_bcd), 32'h000999);
        cycles(1);
        chk("up 1000 ticks", 32'(time_bcd), 32'h001000);
        chk("up running",    32'(running),  32'h1);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);

        // Preload 59:59:98 through a down-mode clear, then count up across rollover.
        mode = 1'b1; preset = 24'h595998;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap preload", 32'(time_bcd), 32'h595998);
        mode = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(10);
        chk("wrap 59:59:99", 32'(time_bcd), 32'h595999);
        chk("wrap early",    32'(wrap),     32'h0);
        cycles(9);
        chk("wrap pre-edge", 32'(wrap),     32'h0);
        cycles(1);
        chk("wrap rollover", 32'(time_bcd), 32'h000000);
        chk("wrap pulse",    32'(wrap),     32'h1);
        cycles(1);
        chk("wrap one cycle", 32'(wrap),    32'h0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);

        // Countdown from 00:00:05.
        mode = 1'b1; preset = 24'h000005;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("down preset", 32'(time_bcd), 32'h000005);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        n_exp = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (expired) n_exp++;
            if (c % 10 == 0)
                chk($sformatf("down step %0d", c / 10), 32'(time_bcd), 32'(5 - c / 10));
        end
        chk("down expired at zero", 32'(expired), 32'h1);
        chk("down expired count",   32'(n_exp),   32'd1);
        chk("down done not running", 32'(running), 32'h0);
        cycles(1);
        chk("down expired one cycle", 32'(expired), 32'h0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(20);
        chk("done ignores start running", 32'(running),  32'h0);
        chk("done ignores start time",    32'(time_bcd), 32'h0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        chk("down clear reload", 32'(time_bcd), 32'h000005);

        // Asynchronous reset mid-run, then first-tick latency.
        mode = 1'b0; preset = 24'h0;
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(25);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre-reset lap_cnt", 32'(lap_cnt), 32'h1);
        rst = 1'b0;
        #1;
        chk("async reset time_bcd", 32'(time_bcd), 32'h0);
        chk("async reset running",  32'(running),  32'h0);
        chk("async reset lap_cnt",  32'(lap_cnt),  32'h0);
        chk("async reset lap_bcd",  32'(lap_bcd),  32'h0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart running", 32'(running), 32'h1);
        cycles(9);
        chk("first tick not early", 32'(time_bcd), 32'h000000);
        cycles(1);
        chk("first tick at 10", 32'(time_bcd), 32'h000001);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised stopwatch/countdown core that succeeds the fixed 1 kHz stopwatch datapath. It counts MM:SS:hh directly in BCD from a configurable clock and tick rate. It supports count-up and count-down-with-preset modes and captures split times into a LAP_DEPTH-entry FIFO. It sits between the key controller (debounced single-cycle command pulses) and the segment controller, which consumes `time_bcd` or `lap_bcd`.

## Interface
- CLK_HZ, 10_000_000, input clock frequency in Hz
- TICK_HZ, 100, count resolution in Hz; CLK_HZ must be an integer multiple of it
- LAP_DEPTH, 4, lap FIFO entries; power of two, 2..16
- rst  in  1  asynchronous, active-low reset
- clk  in  1  clock
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; stop, reload time, flush laps
- lap  in  1  one-cycle pulse; push current time into lap FIFO
- lap_rd  in  1  one-cycle pulse; pop lap FIFO head
- mode  in  1  0 = count up, 1 = count down; sampled only in IDLE
- preset  in  24  BCD MM:SS:hh countdown start value; sampled on clear and on leaving IDLE in down mode
- time_bcd  out  24  current time, {M1,M0,S1,S0,h1,h0}
- lap_bcd  out  24  FIFO head, registered
- lap_cnt  out  $clog2(LAP_DEPTH)+1  FIFO occupancy
- lap_ovf  out  1  sticky; a lap was dropped because the FIFO was full
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when countdown reaches 00:00:00
- wrap  out  1  one-cycle pulse on up-count rollover 59:59:99 -> 00:00:00

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; prescaler 0.
- States:
  - IDLE: after reset or clear.
  - RUN
  - PAUSE
  - DONE: countdown finished.
- Transitions:
  - IDLE -start_stop-> RUN. In down mode, time loads `preset` if time is 0.
  - RUN -start_stop-> PAUSE.
  - PAUSE -start_stop-> RUN.
  - RUN -down count reaches 0-> DONE.
  - Any state -clear-> IDLE.
  - DONE ignores start_stop.
- Mode latch: `mode` is latched on IDLE->RUN and held until the next clear.
- Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1 in RUN only and holds its value in PAUSE. It resets to 0 on clear and on IDLE->RUN. The terminal count produces a one-cycle tick.
- Up count: per-digit BCD cascade with moduli hh 10/10, SS 10/6, MM 10/6. Rollover from 59:59:99 gives 00:00:00 and pulses `wrap`.
- Down count: borrow cascade. The tick that reaches 00:00:00 pulses `expired` and enters DONE, with time held at 0.
- Preset digits above modulus (e.g. S1 > 5): saturate to 9/5 on load.
- Clear: time becomes 0 in up mode or `preset` in down mode. FIFO is flushed, `lap_ovf` is cleared, and wrap/expired are suppressed that cycle.
- Lap accepted in RUN or PAUSE; ignored in IDLE/DONE.
  - When full, the new entry is dropped and `lap_ovf` is set. Stored entries are kept.
  - The captured value is `time_bcd` as of the same cycle, before that cycle's tick update.
- lap_rd on empty: no effect. lap and lap_rd in the same cycle: both happen and occupancy is unchanged, including when full and when empty.
- clear has priority over start_stop, lap and lap_rd in the same cycle.
- start_stop coincident with tick: the tick is applied, then the state changes.

## Timing
- Command pulse at edge n -> state/`running` change visible after edge n+1.
- Tick at edge n -> `time_bcd` updated after edge n+1. `wrap`/`expired` are asserted in that same cycle.
- First tick after IDLE->RUN occurs CLK_HZ/TICK_HZ cycles after `running` rises.
- `lap_bcd` and `lap_cnt` are updated one cycle after lap/lap_rd. `lap_bcd` is 0 when empty.
- No combinational input-to-output path.

## Structure
- Package `lap_timer_pkg`:
  - state enum
  - `bcd_t` (4-bit)
  - `time_t` packed struct of six digits
  - digit modulus constants
  - `TIME_ZERO`, `TIME_MAX`
- Sub-module `bcd_digit`: one BCD digit with modulus parameter, up/down, enable-in, carry/borrow-out, and load. It is instantiated six times.
- FIFO is inline: register array plus pointers.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (10 cycles/tick), up mode: start, wait 1000 ticks -> time_bcd = 00:10:00 and running = 1.
- Preload via force to 59:59:98, run 2 ticks -> 00:00:00; `wrap` pulses for exactly one cycle.
- Down mode, preset 00:00:05, start -> counts 04..00; `expired` pulses once; state DONE; further start_stop ignored. Then clear -> time_bcd = 00:00:05.
- LAP_DEPTH=4: five laps at distinct times -> lap_cnt = 4, lap_ovf = 1. Four lap_rd pulses return the first four times in order; afterwards lap_cnt = 0 and lap_bcd = 0.
- Simultaneous lap + lap_rd with FIFO full -> lap_cnt stays 4, head advances, newest entry stored, lap_ovf unchanged.
- Assert rst mid-RUN -> all outputs 0 immediately. After release, start_stop -> first tick after exactly 10 cycles.
